// File: rtl/io_bus_pkg.sv
// -----------------------------------------------------------------------------
// io_bus_pkg
// Shared definitions for the CPU I/O bus return path. The I/O address decoder
// and io_response_collector both import this package so that dev_sel bit
// positions and the floating-bus read value agree on both sides.
//
// Contents:
//   io_state_e        - response collector FSM states (IDLE, WAIT, DONE)
//   IO_FLOAT_DATA     - read data returned when nobody drives the bus
//   IO_DEV_*          - dev_sel / dev_ack / dev_data slice indices
//   io_byte_addr()    - word address [15:1] to 16-bit byte I/O address
// -----------------------------------------------------------------------------
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } io_state_e;

  // Undriven ISA-style data bus reads back as all ones.
  localparam logic [15:0] IO_FLOAT_DATA = 16'hFFFF;

  localparam int unsigned IO_NUM_DEV     = 16;

  // Select bit indices shared with the I/O address decoder.
  localparam int unsigned IO_DEV_PIC      = 0;
  localparam int unsigned IO_DEV_DMA      = 1;
  localparam int unsigned IO_DEV_DMA_PAGE = 2;
  localparam int unsigned IO_DEV_UART     = 3;
  localparam int unsigned IO_DEV_UART2    = 4;
  localparam int unsigned IO_DEV_MCGA     = 5;
  localparam int unsigned IO_DEV_CGA      = 6;
  localparam int unsigned IO_DEV_TIMER    = 7;
  localparam int unsigned IO_DEV_PPI      = 8;

  // I/O space is 64 KiB; the CPU presents word addresses, so rebuild the
  // even byte address for reporting.
  function automatic logic [15:0] io_byte_addr(input logic [15:1] word_addr);
    io_byte_addr = {word_addr, 1'b0};
  endfunction

endpackage

// File: rtl/io_sel_priority.sv
// -----------------------------------------------------------------------------
// io_sel_priority
// Combinational priority picker for decoded peripheral selects. The decoder
// should only ever raise one select; if it raises several, the lowest index
// wins and multi_hit reports the overlap.
//
// Ports:
//   sel_in     in  NUM_DEV  raw select bits from the I/O decoder
//   sel_onehot out NUM_DEV  lowest-index set bit of sel_in (zero if none)
//   multi_hit  out 1        more than one bit of sel_in is set
// -----------------------------------------------------------------------------
module io_sel_priority #(
  parameter int unsigned NUM_DEV = 16
) (
  input  logic [NUM_DEV-1:0] sel_in,
  output logic [NUM_DEV-1:0] sel_onehot,
  output logic               multi_hit
);

  localparam logic [NUM_DEV-1:0] ONE  = {{(NUM_DEV-1){1'b0}}, 1'b1};
  localparam logic [NUM_DEV-1:0] ZERO = {NUM_DEV{1'b0}};

  logic [NUM_DEV-1:0] minus_one_s;

  // x & -x isolates the lowest set bit; x & (x-1) clears it, leaving any
  // further hits.
  always_comb begin
    minus_one_s = sel_in - ONE;
    sel_onehot  = sel_in & (~sel_in + ONE);
    multi_hit   = ((sel_in & minus_one_s) != ZERO);
  end

endmodule

// File: rtl/io_response_collector.sv
// -----------------------------------------------------------------------------
// io_response_collector
// Return path for CPU I/O cycles. Accepts an I/O access, picks the selected
// peripheral, waits for that peripheral's ack (or terminates unclaimed and
// timed-out cycles itself), and hands the CPU one registered ack plus read
// data. Sticky flags record timeouts and overlapping decoder selects.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   d_io                  current CPU cycle is an I/O cycle
//   data_m_access         CPU request, held until data_m_ack
//   data_m_wr_en          1 = write, 0 = read
//   data_m_addr[19:1]     CPU word address
//   dev_sel               decoder selects (combinational)
//   default_io_access     decoder found no claimant
//   dev_ack               per-peripheral single-cycle ack
//   dev_data              per-peripheral read data, slice i = [16i+15:16i]
//   err_clear             clears sticky flags
//   data_m_data_in        registered read data to CPU
//   data_m_ack            registered single-cycle ack to CPU
//   timeout_flag          sticky: a cycle was ended by timeout
//   timeout_addr          byte address of the first timed-out cycle
//   multi_sel_flag        sticky: overlapping dev_sel seen at acceptance
// -----------------------------------------------------------------------------
module io_response_collector
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_DEV        = IO_NUM_DEV,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [15:0] FLOAT_DATA     = IO_FLOAT_DATA
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   d_io,
  input  logic                   data_m_access,
  input  logic                   data_m_wr_en,
  input  logic [19:1]            data_m_addr,
  input  logic [NUM_DEV-1:0]     dev_sel,
  input  logic                   default_io_access,
  input  logic [NUM_DEV-1:0]     dev_ack,
  input  logic [16*NUM_DEV-1:0]  dev_data,
  input  logic                   err_clear,
  output logic [15:0]            data_m_data_in,
  output logic                   data_m_ack,
  output logic                   timeout_flag,
  output logic [15:0]            timeout_addr,
  output logic                   multi_sel_flag
);

  localparam logic [15:0]        TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]        CNT_MAX   = 16'hFFFF;
  localparam logic [NUM_DEV-1:0] SEL_NONE  = {NUM_DEV{1'b0}};

  io_state_e          state_q, state_d;
  logic [NUM_DEV-1:0] sel_q, sel_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [15:1]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               ack_q, ack_d;
  logic               tflag_q, tflag_d;
  logic [15:0]        taddr_q, taddr_d;
  logic               mflag_q, mflag_d;

  logic [NUM_DEV-1:0] first_sel_s;
  logic               multi_s;
  logic               accept_s;
  logic               default_hit_s;
  logic               same_ack_s;
  logic               wait_ack_s;
  logic               abort_s;

  // Read-data mux driven by a one-hot select.
  function automatic logic [15:0] pick_data(input logic [NUM_DEV-1:0]    sel,
                                            input logic [16*NUM_DEV-1:0] data);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel[i]) begin
        r = r | data[16*i +: 16];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  io_sel_priority #(
    .NUM_DEV (NUM_DEV)
  ) u_sel_priority (
    .sel_in     (dev_sel),
    .sel_onehot (first_sel_s),
    .multi_hit  (multi_s)
  );

  // Event decode shared by the next-state and datapath logic. The !ack_q
  // term keeps a held request from being accepted again during DONE.
  always_comb begin
    accept_s      = (state_q == IDLE) && d_io && data_m_access && !ack_q;
    default_hit_s = default_io_access || (dev_sel == SEL_NONE);
    same_ack_s    = ((dev_ack & first_sel_s) != SEL_NONE);
    wait_ack_s    = ((dev_ack & sel_q) != SEL_NONE);
    abort_s       = !(d_io && data_m_access);
  end

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      cnt_q   <= 16'h0000;
      wr_q    <= 1'b0;
      addr_q  <= 15'h0000;
      data_q  <= 16'h0000;
      ack_q   <= 1'b0;
      tflag_q <= 1'b0;
      taddr_q <= 16'h0000;
      mflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      tflag_q <= tflag_d;
      taddr_q <= taddr_d;
      mflag_q <= mflag_d;
    end
  end

  // Next-state logic. In WAIT an abort beats a coincident ack so that a
  // withdrawn request is never acknowledged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (default_hit_s || same_ack_s) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (wait_ack_s || (cnt_q == TMO_LAST)) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs. The ack flop mirrors entry into DONE so
  // data_m_ack is high for exactly the DONE cycle. Flag sets are applied
  // after the err_clear default so a new error wins over a clear.
  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = (state_d == DONE);
    tflag_d = tflag_q && !err_clear;
    taddr_d = taddr_q;
    mflag_d = mflag_q && !err_clear;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sel_d  = first_sel_s;
          wr_d   = data_m_wr_en;
          addr_d = data_m_addr[15:1];
          if (multi_s) begin
            mflag_d = 1'b1;
          end else begin
            mflag_d = mflag_d;
          end
          if (default_hit_s) begin
            cnt_d  = 16'h0000;
            data_d = data_m_wr_en ? data_q : FLOAT_DATA;
          end else if (same_ack_s) begin
            cnt_d  = 16'h0000;
            data_d = data_m_wr_en ? data_q : pick_data(first_sel_s, dev_data);
          end else begin
            cnt_d  = 16'h0001;
          end
        end else begin
          cnt_d = 16'h0000;
        end
      end
      WAIT: begin
        if (abort_s) begin
          cnt_d = 16'h0000;
        end else if (wait_ack_s) begin
          cnt_d  = 16'h0000;
          data_d = wr_q ? data_q : pick_data(sel_q, dev_data);
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = 16'h0000;
          data_d  = wr_q ? data_q : FLOAT_DATA;
          tflag_d = 1'b1;
          // Only the first timeout since reset is recorded.
          if (!tflag_q) begin
            taddr_d = io_byte_addr(addr_q);
          end else begin
            taddr_d = taddr_q;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 16'h0001;
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE:    cnt_d = 16'h0000;
      default: cnt_d = 16'h0000;
    endcase
  end

  assign data_m_data_in = data_q;
  assign data_m_ack     = ack_q;
  assign timeout_flag   = tflag_q;
  assign timeout_addr   = taddr_q;
  assign multi_sel_flag = mflag_q;

endmodule

// File: tb/tb_io_response_collector.sv
// -----------------------------------------------------------------------------
// tb_io_response_collector
// Directed testbench for io_response_collector. Inputs change 1 ns after the
// rising edge; outputs are sampled at that point as well. Latency n means
// data_m_ack was seen after the n-th rising edge following the drive of the
// request (n = 1 is the acceptance edge's following cycle).
// -----------------------------------------------------------------------------
module tb_io_response_collector;
  import io_bus_pkg::*;

  localparam int NUM_DEV = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  d_io;
  logic                  data_m_access;
  logic                  data_m_wr_en;
  logic [19:1]           data_m_addr;
  logic [NUM_DEV-1:0]    dev_sel;
  logic                  default_io_access;
  logic [NUM_DEV-1:0]    dev_ack;
  logic [16*NUM_DEV-1:0] dev_data;
  logic                  err_clear;
  logic [15:0]           data_m_data_in;
  logic                  data_m_ack;
  logic                  timeout_flag;
  logic [15:0]           timeout_addr;
  logic                  multi_sel_flag;

  int errors = 0;
  int checks = 0;

  io_response_collector #(
    .NUM_DEV        (NUM_DEV),
    .TIMEOUT_CYCLES (64),
    .FLOAT_DATA     (16'hFFFF)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .d_io              (d_io),
    .data_m_access     (data_m_access),
    .data_m_wr_en      (data_m_wr_en),
    .data_m_addr       (data_m_addr),
    .dev_sel           (dev_sel),
    .default_io_access (default_io_access),
    .dev_ack           (dev_ack),
    .dev_data          (dev_data),
    .err_clear         (err_clear),
    .data_m_data_in    (data_m_data_in),
    .data_m_ack        (data_m_ack),
    .timeout_flag      (timeout_flag),
    .timeout_addr      (timeout_addr),
    .multi_sel_flag    (multi_sel_flag)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    d_io              = 1'b0;
    data_m_access     = 1'b0;
    data_m_wr_en      = 1'b0;
    data_m_addr       = 19'h00000;
    dev_sel           = 16'h0000;
    default_io_access = 1'b0;
    dev_ack           = 16'h0000;
    err_clear         = 1'b0;
  endtask

  // Issue one access and return the ack latency (0 = no ack within budget).
  // ack_at = 0 gives a same-cycle ack; ack_at = n drives ack_vec after edge n
  // (sampled at edge n+1); ack_at < 0 means no ack. stray_vec is ORed in
  // after edge stray_at.
  task automatic run_access(input logic [15:0] sel, input logic def,
                            input logic wr, input logic [19:0] byte_addr,
                            input int ack_at, input logic [15:0] ack_vec,
                            input int stray_at, input logic [15:0] stray_vec,
                            output int lat);
    lat = 0;
    @(posedge clk); #1;
    d_io              = 1'b1;
    data_m_access     = 1'b1;
    data_m_wr_en      = wr;
    data_m_addr       = byte_addr[19:1];
    dev_sel           = sel;
    default_io_access = def;
    dev_ack           = (ack_at == 0) ? ack_vec : 16'h0000;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (data_m_ack) begin
        lat = n;
        break;
      end
      dev_ack = 16'h0000;
      if (n == ack_at)   dev_ack = ack_vec;
      if (n == stray_at) dev_ack = dev_ack | stray_vec;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    dev_data = '0;
    dev_data[16*IO_DEV_PIC   +: 16] = 16'h1234;
    dev_data[16*IO_DEV_UART  +: 16] = 16'hBEEF;
    dev_data[16*IO_DEV_TIMER +: 16] = 16'h00A5;
    dev_data[16*IO_DEV_PPI   +: 16] = 16'h5555;
    #22;
    checks += 5;
    if (data_m_ack !== 1'b0)          begin errors++; $display("FAIL reset_ack got=%b exp=0", data_m_ack); end
    if (data_m_data_in !== 16'h0000)  begin errors++; $display("FAIL reset_data got=%h exp=0000", data_m_data_in); end
    if (timeout_flag !== 1'b0)        begin errors++; $display("FAIL reset_tflag got=%b exp=0", timeout_flag); end
    if (timeout_addr !== 16'h0000)    begin errors++; $display("FAIL reset_taddr got=%h exp=0000", timeout_addr); end
    if (multi_sel_flag !== 1'b0)      begin errors++; $display("FAIL reset_mflag got=%b exp=0", multi_sel_flag); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_default();
    int lat;
    run_access(16'h0000, 1'b1, 1'b0, 20'h00378, -1, 16'h0000, -1, 16'h0000, lat);
    checks += 4;
    if (lat !== 1)                    begin errors++; $display("FAIL default_lat got=%0d exp=1", lat); end
    if (data_m_data_in !== 16'hFFFF)  begin errors++; $display("FAIL default_data got=%h exp=ffff", data_m_data_in); end
    if (timeout_flag !== 1'b0)        begin errors++; $display("FAIL default_tflag got=%b exp=0", timeout_flag); end
    if (multi_sel_flag !== 1'b0)      begin errors++; $display("FAIL default_mflag got=%b exp=0", multi_sel_flag); end
  endtask

  task automatic test_delayed_ack();
    int lat;
    run_access(16'h0080, 1'b0, 1'b0, 20'h00040, 3, 16'h0080, -1, 16'h0000, lat);
    checks += 2;
    if (lat !== 4)                    begin errors++; $display("FAIL delayed_lat got=%0d exp=4", lat); end
    if (data_m_data_in !== 16'h00A5)  begin errors++; $display("FAIL delayed_data got=%h exp=00a5", data_m_data_in); end
  endtask

  task automatic test_timeout();
    int lat;
    run_access(16'h0008, 1'b0, 1'b0, 20'h003F8, -1, 16'h0000, -1, 16'h0000, lat);
    checks += 4;
    if (lat !== 64)                   begin errors++; $display("FAIL timeout_lat got=%0d exp=64", lat); end
    if (data_m_data_in !== 16'hFFFF)  begin errors++; $display("FAIL timeout_data got=%h exp=ffff", data_m_data_in); end
    if (timeout_flag !== 1'b1)        begin errors++; $display("FAIL timeout_flag got=%b exp=1", timeout_flag); end
    if (timeout_addr !== 16'h03F8)    begin errors++; $display("FAIL timeout_addr got=%h exp=03f8", timeout_addr); end
    run_access(16'h0008, 1'b0, 1'b0, 20'h002F8, -1, 16'h0000, -1, 16'h0000, lat);
    checks += 2;
    if (lat !== 64)                   begin errors++; $display("FAIL timeout2_lat got=%0d exp=64", lat); end
    if (timeout_addr !== 16'h03F8)    begin errors++; $display("FAIL timeout2_addr got=%h exp=03f8", timeout_addr); end
  endtask

  task automatic test_err_clear();
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    checks += 2;
    if (timeout_flag !== 1'b0)        begin errors++; $display("FAIL clear_tflag got=%b exp=0", timeout_flag); end
    if (timeout_addr !== 16'h03F8)    begin errors++; $display("FAIL clear_taddr got=%h exp=03f8", timeout_addr); end
  endtask

  task automatic test_multi_sel();
    int lat;
    // PIC and UART both selected; a UART ack during WAIT must be ignored.
    run_access(16'h0009, 1'b0, 1'b0, 20'h00020, 2, 16'h0001, 1, 16'h0008, lat);
    checks += 3;
    if (lat !== 3)                    begin errors++; $display("FAIL multi_lat got=%0d exp=3", lat); end
    if (data_m_data_in !== 16'h1234)  begin errors++; $display("FAIL multi_data got=%h exp=1234", data_m_data_in); end
    if (multi_sel_flag !== 1'b1)      begin errors++; $display("FAIL multi_flag got=%b exp=1", multi_sel_flag); end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    d_io          = 1'b1;
    data_m_access = 1'b1;
    data_m_addr   = 19'h001FC;
    dev_sel       = 16'h0008;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (data_m_ack) seen++;
      if (n == 5) data_m_access = 1'b0;
      dev_ack = (n == 7) ? 16'h0008 : 16'h0000;
    end
    idle_inputs();
    checks += 4;
    if (seen !== 0)                   begin errors++; $display("FAIL abort_ack got=%0d exp=0", seen); end
    if (data_m_data_in !== 16'h1234)  begin errors++; $display("FAIL abort_data got=%h exp=1234", data_m_data_in); end
    if (timeout_flag !== 1'b0)        begin errors++; $display("FAIL abort_tflag got=%b exp=0", timeout_flag); end
    if (multi_sel_flag !== 1'b1)      begin errors++; $display("FAIL abort_mflag got=%b exp=1", multi_sel_flag); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    exp_ack = 4'b0101;
    @(posedge clk); #1;
    d_io          = 1'b1;
    data_m_access = 1'b1;
    data_m_wr_en  = 1'b1;
    data_m_addr   = 19'h00030;
    dev_sel       = 16'h0100;
    dev_ack       = 16'h0100;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      checks++;
      if (data_m_ack !== exp_ack[n-1]) begin
        errors++;
        $display("FAIL b2b_ack_%0d got=%b exp=%b", n, data_m_ack, exp_ack[n-1]);
      end
    end
    idle_inputs();
    checks++;
    if (data_m_data_in !== 16'h1234)  begin errors++; $display("FAIL b2b_wr_data got=%h exp=1234", data_m_data_in); end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    d_io          = 1'b1;
    data_m_access = 1'b1;
    data_m_addr   = 19'h001FC;
    dev_sel       = 16'h0008;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (data_m_ack !== 1'b0)          begin errors++; $display("FAIL rst_ack got=%b exp=0", data_m_ack); end
    if (data_m_data_in !== 16'h0000)  begin errors++; $display("FAIL rst_data got=%h exp=0000", data_m_data_in); end
    if (timeout_flag !== 1'b0)        begin errors++; $display("FAIL rst_tflag got=%b exp=0", timeout_flag); end
    if (timeout_addr !== 16'h0000)    begin errors++; $display("FAIL rst_taddr got=%h exp=0000", timeout_addr); end
    if (multi_sel_flag !== 1'b0)      begin errors++; $display("FAIL rst_mflag got=%b exp=0", multi_sel_flag); end
    // Request still held: after release a fresh cycle starts and cannot
    // finish inside this window.
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (data_m_ack) seen++;
    end
    idle_inputs();
    checks++;
    if (seen !== 0)                   begin errors++; $display("FAIL rst_no_ack got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_delayed_ack();
    test_timeout();
    test_err_clear();
    test_multi_sel();
    test_abort();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_response_collector.md
Name: io_response_collector

Overview:
- Return path for CPU I/O cycles. Takes the per-peripheral chip selects produced by the I/O address decoder, waits for the selected peripheral's ack, and returns one registered ack plus read data to the CPU data master.
- Terminates unclaimed (default_io) cycles and cycles to peripherals that never ack, so the CPU cannot hang.
- Sits between the I/O decoder / peripheral bank and the CPU data bus.

Parameters:
- NUM_DEV, 16, number of decoded peripheral selects (PIC, PIT, UART, UART2, DMA, DMA page, CGA, MCGA, PPI, ...).
- TIMEOUT_CYCLES, 64, cycles from acceptance to forced ack; legal range 2..65535.
- FLOAT_DATA, 16'hFFFF, read data returned for default/timeout cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- d_io  in  1  current cycle is an I/O cycle
- data_m_access  in  1  CPU data access request; held until data_m_ack
- data_m_wr_en  in  1  1 = write, 0 = read
- data_m_addr  in  19  word address [19:1]
- dev_sel  in  NUM_DEV  one-hot selects from the decoder (combinational)
- default_io_access  in  1  decoder found no claimant
- dev_ack  in  NUM_DEV  per-peripheral single-cycle ack
- dev_data  in  16*NUM_DEV  per-peripheral read data; slice i = [16i+15:16i]
- err_clear  in  1  clears sticky error flags
- data_m_data_in  out  16  registered read data to CPU
- data_m_ack  out  1  single-cycle registered ack to CPU
- timeout_flag  out  1  sticky: a cycle was terminated by timeout
- timeout_addr  out  16  byte I/O address {data_m_addr[15:1],1'b0} of the first timed-out cycle
- multi_sel_flag  out  1  sticky: more than one dev_sel bit set at acceptance

Behaviour:
- Reset (async, reset_n=0): state IDLE; data_m_ack=0; data_m_data_in=0; timeout_flag=0; timeout_addr=0; multi_sel_flag=0; counter=0.
- States: IDLE, WAIT, DONE.
- IDLE: acceptance when d_io && data_m_access && !data_m_ack. At acceptance:
  - latch sel = lowest-index set bit of dev_sel;
  - if popcount(dev_sel) > 1, set multi_sel_flag.
- Default path: if default_io_access || dev_sel==0 → go to DONE with data = FLOAT_DATA (writes discarded). data_m_ack asserts the cycle after acceptance (latency 1).
- Same-cycle ack: if dev_ack[sel] is set in the acceptance cycle → capture dev_data slice (reads) and go to DONE; ack the next cycle.
- Otherwise → WAIT with counter = 1.
- WAIT: only dev_ack[sel] is honoured; other acks are ignored.
  - On dev_ack[sel]: capture data, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: data = FLOAT_DATA; if timeout_flag==0, latch timeout_addr; set timeout_flag; go to DONE.
  - Else counter++.
- DONE: data_m_ack=1 for exactly one cycle; data_m_data_in valid in that same cycle; then return to IDLE.
- data_m_ack is low in IDLE and WAIT.
- Back-to-back cycles: a new access is accepted no earlier than the cycle after data_m_ack (the !data_m_ack guard).
- Abort: data_m_access or d_io falling in WAIT → IDLE, no ack, flags unchanged. A late dev_ack is then ignored.
- Stray dev_ack in IDLE: ignored.
- Writes: ack timing is identical to reads; data_m_data_in is left unchanged.
- data_m_data_in holds its value between acks.
- err_clear: clears both flags next cycle. If err_clear and a new error occur in the same cycle, the set wins. timeout_addr is not cleared.
- Timeout ack lands exactly TIMEOUT_CYCLES cycles after acceptance when no ack arrives.
- Counter is 16 bits, saturating; no wrap.
- Reset asserted mid-WAIT: immediate return to IDLE; no ack is issued.

Decomposition:
- Shared package io_bus_pkg:
  - state typedef enum {IDLE, WAIT, DONE};
  - IO_FLOAT_DATA constant;
  - localparams for dev_sel bit indices (PIC=0, DMA=1, DMA_PAGE=2, UART=3, UART2=4, MCGA=5, CGA=6, TIMER=7, PPI=8, ...) so the decoder and this block agree.
- One sub-module: io_sel_priority. Combinational; takes NUM_DEV select bits and produces the lowest-index one-hot plus a multi-hit flag. Instantiated once.

Test Plan:
- Default cycle: d_io=1, access=1, default_io_access=1, read at 0x0378 → data_m_ack one cycle after acceptance, data_m_data_in=16'hFFFF, no flags set.
- Delayed ack: dev_sel[TIMER]=1, read at 0x0040, dev_ack[TIMER] 3 cycles after acceptance with data 16'h00A5 → ack 4 cycles after acceptance, data 16'h00A5.
- Timeout: dev_sel[UART]=1, read at 0x03F8, no ack → ack exactly 64 cycles after acceptance with 16'hFFFF, timeout_flag=1, timeout_addr=16'h03F8. Repeat at 0x02F8 → timeout_addr stays 16'h03F8. Pulse err_clear → timeout_flag=0.
- Multi-select and stray ack: dev_sel=16'h0009 → PIC (bit 0) serviced, multi_sel_flag=1. dev_ack[3] asserted during WAIT → ignored.
- Abort and back-to-back:
  - drop data_m_access at WAIT cycle 5 → no ack; a late dev_ack is ignored;
  - then two consecutive writes with same-cycle ack → acks one cycle after each acceptance, one idle cycle between acks;
  - reset_n pulsed low mid-WAIT → all outputs return to 0 asynchronously.
